can_bus_regif: RTL and testbench

- Parametrised host-side register slave for the CAN controller, sitting between the bus2ip/ip2bus host interface and the CAN protocol core.
- Adds over the previous bus model:
  - one access per chip-select assertion (edge-qualified),
  - address/permission error reporting,
  - a maskable write-1-to-clear interrupt block,
  - a depth-parametrised TX word FIFO toward the core.

---
 rtl/can_regif_pkg.sv | 45 ++++
 rtl/can_tx_fifo.sv | 76 +++++++
 rtl/can_bus_regif.sv | 204 ++++++++++++++++++++
 tb/tb_can_bus_regif.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_regif_pkg.sv
// can_regif_pkg: shared constants for the CAN host register slave.
//   - Register word addresses and the FLUSH bit position in CTRL.
//   - Access FSM state encoding (IDLE, ACCESS, HOLD).
//   - reg_perm(): decodes an address into legal/readable/writable flags.
package can_regif_pkg;

  // Access FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Register word addresses
  localparam int unsigned ADDR_CTRL    = 0;
  localparam int unsigned ADDR_STATUS  = 1;
  localparam int unsigned ADDR_ISR     = 2;
  localparam int unsigned ADDR_IER     = 3;
  localparam int unsigned ADDR_TXDATA  = 4;
  localparam int unsigned ADDR_TXLEVEL = 5;
  localparam int unsigned ADDR_SCRATCH = 6;

  localparam int unsigned CTRL_FLUSH_BIT = 0;

  typedef struct packed {
    logic valid;
    logic readable;
    logic writable;
  } reg_perm_t;

  // Static access rights per address; the scratch word only exists when enabled.
  function automatic reg_perm_t reg_perm(input int unsigned addr, input logic scratch_en);
    reg_perm_t p;
    p = '0;
    case (addr)
      ADDR_CTRL, ADDR_ISR, ADDR_IER: p = '{valid: 1'b1, readable: 1'b1, writable: 1'b1};
      ADDR_STATUS, ADDR_TXLEVEL:     p = '{valid: 1'b1, readable: 1'b1, writable: 1'b0};
      ADDR_TXDATA:                   p = '{valid: 1'b1, readable: 1'b0, writable: 1'b1};
      ADDR_SCRATCH: begin
        if (scratch_en) p = '{valid: 1'b1, readable: 1'b1, writable: 1'b1};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/can_tx_fifo.sv
// can_tx_fifo: word FIFO carrying host TX data toward the CAN core.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data enqueue request and word (ignored when full)
//   pop             dequeue request (ignored when empty)
//   flush           empties the FIFO; wins over a coincident pop or push
//   full, empty     status, evaluated on the pre-update occupancy
//   level           entry count, clog2(FIFO_DEPTH)+1 bits
//   head            oldest entry, zero while empty
// FIFO_DEPTH must be a power of two (pointers wrap by overflow).
module can_tx_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             push_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [DATA_W-1:0]             head
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/can_bus_regif.sv
// can_bus_regif: host-side register slave for the CAN controller.
// One register access per chip-select assertion; ack one cycle after cs is first sampled.
// Ports:
//   sys_clk, bus2ip_reset        clock, asynchronous active-high reset
//   bus2ip_cs/rnw/addr/data      host request (addr/data use bit 0 = MSB numbering)
//   ip2bus_data/ack/error        one-cycle response; data is zero outside ack or on error
//   ip2bus_intrevent             registered OR of (ISR & IER)
//   irq_src                      interrupt event strobes from the core
//   core_status                  live status word, read at STATUS
//   tx_data/tx_valid/tx_ready    TX FIFO head toward the core
// Build option: define CAN_REGIF_SCRATCH_EN to add a RW scratch word at address 6.
module can_bus_regif
  import can_regif_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_IRQ    = 4
) (
  input  logic                sys_clk,
  input  logic                bus2ip_reset,
  input  logic                bus2ip_cs,
  input  logic                bus2ip_rnw,
  input  logic [0:ADDR_W-1]   bus2ip_addr,
  input  logic [0:DATA_W-1]   bus2ip_data,
  output logic [0:DATA_W-1]   ip2bus_data,
  output logic                ip2bus_ack,
  output logic                ip2bus_error,
  output logic                ip2bus_intrevent,
  input  logic [NUM_IRQ-1:0]  irq_src,
  input  logic [DATA_W-1:0]   core_status,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
);

`ifdef CAN_REGIF_SCRATCH_EN
  localparam logic SCRATCH_EN = 1'b1;
`else
  localparam logic SCRATCH_EN = 1'b0;
`endif
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Host vectors are MSB-first; plain assignment keeps the numeric value.
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wdata;
  int unsigned        addr_idx;

  logic [1:0]         state_q, state_d;
  logic [DATA_W-1:0]  ctrl_q, ctrl_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] ier_q, ier_d;
  logic [DATA_W-1:0]  scratch_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               ack_q;
  logic               err_q;
  logic               intr_q;

  reg_perm_t          perm;
  logic               start;
  logic               acc_err;
  logic               wr_en;
  logic               rd_en;
  logic [DATA_W-1:0]  rd_mux;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_level;
  logic [DATA_W-1:0]  fifo_head;

  assign addr     = bus2ip_addr;
  assign wdata    = bus2ip_data;
  assign addr_idx = 32'(addr);

  // The register action happens on the same edge that accepts the access.
  assign start   = (state_q == ST_IDLE) && bus2ip_cs;
  assign perm    = reg_perm(addr_idx, SCRATCH_EN);
  assign wr_en   = start && !bus2ip_rnw && !acc_err;
  assign rd_en   = start && bus2ip_rnw && !acc_err;

  always_comb begin
    acc_err = 1'b0;
    if (!perm.valid) begin
      acc_err = 1'b1;
    end else if (bus2ip_rnw) begin
      acc_err = !perm.readable;
    end else begin
      // Fullness is taken before any same-cycle pop, so a push into a full FIFO is refused.
      acc_err = !perm.writable || ((addr_idx == ADDR_TXDATA) && fifo_full);
    end
  end

  // Access FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus2ip_cs) state_d = ST_ACCESS;
      // A cs already released during the ack cycle skips HOLD.
      ST_ACCESS: state_d = bus2ip_cs ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (!bus2ip_cs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Register next-state
  always_comb begin
    ctrl_d     = ctrl_q;
    ier_d      = ier_q;
    isr_d      = isr_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (wr_en) begin
      case (addr_idx)
        ADDR_CTRL: begin
          ctrl_d                 = wdata;
          ctrl_d[CTRL_FLUSH_BIT] = 1'b0;
          fifo_flush             = wdata[CTRL_FLUSH_BIT];
        end
        ADDR_ISR:    isr_d     = isr_q & ~wdata[NUM_IRQ-1:0];
        ADDR_IER:    ier_d     = wdata[NUM_IRQ-1:0];
        ADDR_TXDATA: fifo_push = 1'b1;
        default: ;
      endcase
    end
    // New events win over a coincident host clear.
    isr_d = isr_d | irq_src;
  end

  always_comb begin
    rd_mux = '0;
    case (addr_idx)
      ADDR_CTRL:    rd_mux = ctrl_q;
      ADDR_STATUS:  rd_mux = core_status;
      ADDR_ISR:     rd_mux[NUM_IRQ-1:0] = isr_q;
      ADDR_IER:     rd_mux[NUM_IRQ-1:0] = ier_q;
      ADDR_TXLEVEL: rd_mux[CNT_W-1:0] = fifo_level;
      ADDR_SCRATCH: rd_mux = scratch_q;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge bus2ip_reset) begin
    if (bus2ip_reset) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      isr_q   <= '0;
      ier_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      isr_q   <= isr_d;
      ier_q   <= ier_d;
      rdata_q <= rd_en ? rd_mux : '0;
      ack_q   <= start;
      err_q   <= start && acc_err;
      intr_q  <= |(isr_q & ier_q);
    end
  end

`ifdef CAN_REGIF_SCRATCH_EN
  always_ff @(posedge sys_clk or posedge bus2ip_reset) begin
    if (bus2ip_reset) begin
      scratch_q <= '0;
    end else if (wr_en && (addr_idx == ADDR_SCRATCH)) begin
      scratch_q <= wdata;
    end
  end
`else
  assign scratch_q = '0;
`endif

  assign fifo_pop = tx_ready && !fifo_empty;

  can_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (sys_clk),
    .rst       (bus2ip_reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .push_data (wdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (fifo_head)
  );

  assign ip2bus_data      = rdata_q;
  assign ip2bus_ack       = ack_q;
  assign ip2bus_error     = err_q;
  assign ip2bus_intrevent = intr_q;
  assign tx_data          = fifo_head;
  assign tx_valid         = !fifo_empty;

endmodule

// File: tb/tb_can_bus_regif.sv
// Bench for can_bus_regif: directed vector table, hand sequences for FIFO drain,
// interrupts and reset mid-access, then random accesses against a queue-based model.
module tb_can_bus_regif;

  localparam int DEPTH = 4;
  localparam logic [31:0] STATUS_VAL = 32'hC0DE_1234;

  logic        sys_clk;
  logic        bus2ip_reset;
  logic        bus2ip_cs;
  logic        bus2ip_rnw;
  logic [5:0]  bus2ip_addr;
  logic [31:0] bus2ip_data;
  logic [31:0] ip2bus_data;
  logic        ip2bus_ack;
  logic        ip2bus_error;
  logic        ip2bus_intrevent;
  logic [3:0]  irq_src;
  logic [31:0] core_status;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  can_bus_regif dut (
    .sys_clk          (sys_clk),
    .bus2ip_reset     (bus2ip_reset),
    .bus2ip_cs        (bus2ip_cs),
    .bus2ip_rnw       (bus2ip_rnw),
    .bus2ip_addr      (bus2ip_addr),
    .bus2ip_data      (bus2ip_data),
    .ip2bus_data      (ip2bus_data),
    .ip2bus_ack       (ip2bus_ack),
    .ip2bus_error     (ip2bus_error),
    .ip2bus_intrevent (ip2bus_intrevent),
    .irq_src          (irq_src),
    .core_status      (core_status),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ctrl, m_scratch;
  logic [3:0]  m_isr, m_ier;
  logic [31:0] m_q[$];
  logic [31:0] dut_pops[$];
  logic        rnd_en;

  typedef struct {
    logic        rnw;
    int          addr;
    logic [31:0] wd;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_scratch = '0; m_isr = '0; m_ier = '0;
    m_q.delete();
  endtask

  function automatic logic model_err(input logic rnw, input int addr, input int lvl);
    case (addr)
      0, 2, 3: return 1'b0;
      1, 5:    return !rnw;
      4:       return rnw || (lvl == DEPTH);
`ifdef CAN_REGIF_SCRATCH_EN
      6:       return 1'b0;
`endif
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int addr);
    case (addr)
      0: return m_ctrl;
      1: return STATUS_VAL;
      2: return {28'd0, m_isr};
      3: return {28'd0, m_ier};
      5: return 32'(m_q.size());
      6: return m_scratch;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: update the model for the coming rising edge, then sample at the falling edge.
  task automatic step(input logic act, input logic rnw, input int addr, input logic [31:0] wd);
    logic       exp_intr, full, popv, flush, push;
    logic [3:0] clr;
    if (rnd_en) begin
      irq_src  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      tx_ready = 1'($urandom_range(0, 1));
    end
    exp_intr = |(m_isr & m_ier);
    full  = (m_q.size() == DEPTH);
    popv  = (m_q.size() > 0) && tx_ready;
    flush = 1'b0; push = 1'b0; clr = '0;
    if (act && !model_err(rnw, addr, m_q.size()) && !rnw) begin
      case (addr)
        0: begin m_ctrl = wd & ~32'h1; flush = wd[0]; end
        2: clr = wd[3:0];
        3: m_ier = wd[3:0];
        4: push = !full;
        6: m_scratch = wd;
        default: ;
      endcase
    end
    if (tx_valid && tx_ready) dut_pops.push_back(tx_data);
    if (flush) m_q.delete();
    else begin
      if (popv) void'(m_q.pop_front());
      if (push) m_q.push_back(wd);
    end
    m_isr = (m_isr & ~clr) | irq_src;
    @(negedge sys_clk);
    check("intrevent", ip2bus_intrevent, exp_intr);
    check("tx_valid", tx_valid, m_q.size() != 0);
    check("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
    if (!rnd_en) irq_src = '0;
  endtask

  task automatic do_access(input logic rnw, input int addr, input logic [31:0] wd, input int hold,
                           output logic [31:0] rd, output logic er, output int acks,
                           output int lat, output logic p_err, output logic [31:0] p_rd);
    p_err = model_err(rnw, addr, m_q.size());
    p_rd  = (rnw && !p_err) ? model_read(addr) : 32'd0;
    bus2ip_cs = 1'b1; bus2ip_rnw = rnw; bus2ip_addr = 6'(addr); bus2ip_data = wd;
    acks = 0; lat = -1; rd = '0; er = 1'b0;
    for (int c = 1; c <= hold + 2; c++) begin
      if (c == hold + 1) bus2ip_cs = 1'b0;
      step(c == 1, rnw, addr, wd);
      if (ip2bus_ack) begin
        acks++;
        if (lat < 0) lat = c;
        rd = ip2bus_data;
        er = ip2bus_error;
      end
    end
  endtask

  // Access checked against fixed expectations.
  task automatic acc_fixed(input string nm, input logic rnw, input int addr, input logic [31:0] wd,
                           input int hold, input logic exp_err, input logic [31:0] exp_rd);
    logic [31:0] rd, p_rd;
    logic er, p_err;
    int acks, lat;
    do_access(rnw, addr, wd, hold, rd, er, acks, lat, p_err, p_rd);
    check({nm, "_acks"}, acks, 1);
    check({nm, "_lat"}, lat, 1);
    check({nm, "_err"}, er, exp_err);
    if (rnw) check({nm, "_rdata"}, rd, exp_rd);
  endtask

  function automatic vec_t mk(input logic rnw, input int addr, input logic [31:0] wd,
                              input int hold, input logic exp_err, input logic [31:0] exp_rd);
    vec_t v;
    v.rnw = rnw; v.addr = addr; v.wd = wd; v.hold = hold; v.exp_err = exp_err; v.exp_rd = exp_rd;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] exp_words[4];
    logic [31:0] rd, p_rd;
    logic er, p_err;
    int acks, lat, split;

    exp_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    bus2ip_reset = 1'b1; bus2ip_cs = 1'b0; bus2ip_rnw = 1'b0; bus2ip_addr = '0;
    bus2ip_data = '0; irq_src = '0; core_status = STATUS_VAL; tx_ready = 1'b0; rnd_en = 1'b0;
    model_reset();

    // Phase A: IER masking, FIFO fill and overflow
    vecs.push_back(mk(0, 3, 32'd42, 5, 0, 0));
    vecs.push_back(mk(1, 3, 0, 1, 0, 32'd10));
    vecs.push_back(mk(0, 4, 32'h11, 2, 0, 0));
    vecs.push_back(mk(0, 4, 32'h22, 2, 0, 0));
    vecs.push_back(mk(0, 4, 32'h33, 1, 0, 0));
    vecs.push_back(mk(0, 4, 32'h44, 3, 0, 0));
    vecs.push_back(mk(1, 5, 0, 2, 0, 32'd4));
    vecs.push_back(mk(0, 4, 32'h55, 2, 1, 0));
    vecs.push_back(mk(1, 5, 0, 2, 0, 32'd4));
    split = vecs.size();
    // Phase B: permission errors, flush, status, scratch
    vecs.push_back(mk(0, 1, 32'h1234, 2, 1, 0));
    vecs.push_back(mk(1, 4, 0, 2, 1, 0));
    vecs.push_back(mk(1, 7, 0, 2, 1, 0));
    vecs.push_back(mk(0, 7, 32'hFFFF, 2, 1, 0));
    vecs.push_back(mk(0, 5, 32'h7, 2, 1, 0));
    vecs.push_back(mk(1, 63, 0, 1, 1, 0));
    vecs.push_back(mk(1, 3, 0, 2, 0, 32'd10));
    vecs.push_back(mk(0, 4, 32'hA1, 2, 0, 0));
    vecs.push_back(mk(0, 4, 32'hA2, 2, 0, 0));
    vecs.push_back(mk(1, 5, 0, 2, 0, 32'd2));
    vecs.push_back(mk(0, 0, 32'hF0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2, 0, 32'hF0));
    vecs.push_back(mk(0, 0, 32'h3, 2, 0, 0));
    vecs.push_back(mk(1, 5, 0, 2, 0, 32'd0));
    vecs.push_back(mk(1, 0, 0, 2, 0, 32'h2));
    vecs.push_back(mk(1, 1, 0, 2, 0, STATUS_VAL));
`ifdef CAN_REGIF_SCRATCH_EN
    vecs.push_back(mk(0, 6, 32'hDEADBEEF, 2, 0, 0));
    vecs.push_back(mk(1, 6, 0, 2, 0, 32'hDEADBEEF));
`else
    vecs.push_back(mk(0, 6, 32'hDEADBEEF, 2, 1, 0));
    vecs.push_back(mk(1, 6, 0, 2, 1, 32'd0));
`endif

    // Reset state
    repeat (2) @(negedge sys_clk);
    check("rst_ack", ip2bus_ack, 0);
    check("rst_error", ip2bus_error, 0);
    check("rst_data", ip2bus_data, 0);
    check("rst_intr", ip2bus_intrevent, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    bus2ip_reset = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < split; i++)
      acc_fixed($sformatf("vec%0d", i), vecs[i].rnw, vecs[i].addr, vecs[i].wd, vecs[i].hold,
                vecs[i].exp_err, vecs[i].exp_rd);

    // Drain in order once the core is ready
    dut_pops.delete();
    tx_ready = 1'b1;
    for (int k = 0; k < 10 && tx_valid; k++) step(0, 0, 0, 0);
    check("drain_empty", tx_valid, 0);
    check("drain_count", dut_pops.size(), 4);
    for (int k = 0; k < 4 && k < dut_pops.size(); k++)
      check($sformatf("drain_word%0d", k), dut_pops[k], exp_words[k]);
    tx_ready = 1'b0;

    for (int i = split; i < vecs.size(); i++)
      acc_fixed($sformatf("vec%0d", i), vecs[i].rnw, vecs[i].addr, vecs[i].wd, vecs[i].hold,
                vecs[i].exp_err, vecs[i].exp_rd);

    // Interrupts: set, set-wins-over-clear, clear
    acc_fixed("ier1", 0, 3, 32'h1, 2, 0, 0);
    irq_src = 4'h1;
    step(0, 0, 0, 0);
    check("intr_first_cycle", ip2bus_intrevent, 0);
    step(0, 0, 0, 0);
    check("intr_set", ip2bus_intrevent, 1);
    irq_src = 4'h1;
    acc_fixed("isr_clr_vs_set", 0, 2, 32'h1, 2, 0, 0);
    acc_fixed("isr_after_race", 1, 2, 0, 2, 0, 32'h1);
    acc_fixed("isr_clr", 0, 2, 32'h1, 2, 0, 0);
    step(0, 0, 0, 0);
    check("intr_cleared", ip2bus_intrevent, 0);
    acc_fixed("isr_zero", 1, 2, 0, 2, 0, 32'h0);

    // Reset during ACCESS: outputs clear and no ack follows
    acc_fixed("pre_rst_push", 0, 4, 32'h99, 2, 0, 0);
    irq_src = 4'h1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    bus2ip_cs = 1'b1; bus2ip_rnw = 1'b0; bus2ip_addr = 6'd3; bus2ip_data = 32'hF;
    @(posedge sys_clk);
    #1 bus2ip_reset = 1'b1;
    #1;
    check("midrst_ack", ip2bus_ack, 0);
    check("midrst_error", ip2bus_error, 0);
    check("midrst_data", ip2bus_data, 0);
    check("midrst_intr", ip2bus_intrevent, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_tx_data", tx_data, 0);
    @(negedge sys_clk);
    bus2ip_cs = 1'b0;
    @(negedge sys_clk);
    bus2ip_reset = 1'b0;
    model_reset();
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      if (ip2bus_ack) acks++;
    end
    check("midrst_no_ack", acks, 0);
    acc_fixed("midrst_ier", 1, 3, 0, 2, 0, 32'h0);

    // Random phase against the model
    rnd_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int a;
      logic r;
      logic [31:0] w;
      a = ($urandom_range(0, 9) == 9) ? 63 : int'($urandom_range(0, 7));
      r = 1'($urandom_range(0, 1));
      w = $urandom;
      if (a == 0 && $urandom_range(0, 3) != 0) w[0] = 1'b0;
      do_access(r, a, w, int'($urandom_range(1, 4)), rd, er, acks, lat, p_err, p_rd);
      check($sformatf("rnd%0d_acks", n), acks, 1);
      check($sformatf("rnd%0d_lat", n), lat, 1);
      check($sformatf("rnd%0d_err", n), er, p_err);
      if (r) check($sformatf("rnd%0d_rdata", n), rd, p_rd);
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 0);
    end
    rnd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
